time_alu_sequencer: RTL and testbench
=====================================

TIME_ALU_SEQUENCER -- requirements
Module: time_alu_sequencer

Interface
REQ-001 Ports SHALL be: clk input 1, the single clock; rst_n input 1, a synchronous active-low reset sampled on the rising edge of clk.
REQ-002 tick input 1 SHALL be a one-clk pulse marking one second.
REQ-003 adj_req input 1 SHALL request a user adjust; adj_field input 2 selects the field (00 sec, 01 min, 10 hour, 11 reserved); adj_dir input 1 selects direction (0 up, 1 down).
REQ-004 adj_ack output 1 SHALL pulse for one clk when the adjust is committed.
REQ-005 alu_a, alu_b output 6 each, alu_s output 2 and alu_cin output 1 SHALL drive the shared 6-bit ALU.
REQ-006 alu_data input 6 and alu_cout input 1 SHALL return the combinational ALU result within the same cycle.
REQ-007 sec, min and hour output 6 each SHALL be the registered time fields.
REQ-008 busy output 1 SHALL be high in any non-IDLE state.
REQ-009 tick_ovf output 1 SHALL be a sticky tick-lost flag.

Function
REQ-010 ALU encoding SHALL be: add is alu_s=00, alu_b=1, alu_cin=0; subtract is alu_s=01, alu_b=1, alu_cin=1 (A+~B+1).
REQ-011 Outside ADD/SUB states, alu_s SHALL be 00, and alu_a, alu_b and alu_cin SHALL be 0.
REQ-012 FSM states SHALL be IDLE, T_SEC, T_MIN, T_HR, ADJ; each non-IDLE state SHALL use exactly one ALU operation and last one cycle.
REQ-013 IDLE arbitration: a pending tick (tick or tick_pend) SHALL win over adj_req; if it wins, go to T_SEC, otherwise if adj_req then go to ADJ.
REQ-014 T_SEC SHALL compute sec+1; result 60 writes sec=0 then T_MIN, else writes result then IDLE.
REQ-015 T_MIN SHALL behave the same as T_SEC on min (limit 60), going to T_HR on wrap.
REQ-016 T_HR SHALL compute hour+1; result 24 writes 0; it then goes to IDLE.
REQ-017 Tick-to-update latency: sec SHALL update at the edge ending T_SEC, which is 1 cycle after tick is sampled in IDLE.
REQ-018 Worst-case tick service (23:59:59) SHALL be 3 cycles.
REQ-019 ADJ up SHALL use the field's wrap rule with no carry into other fields.
REQ-020 ADJ down SHALL subtract 1; if alu_cout=0 (borrow, field was 0), the field SHALL load limit-1 (59/59/23).
REQ-021 ADJ SHALL assert adj_ack in the same cycle, then return to IDLE.
REQ-022 adj_field=11 SHALL cause no field write, but adj_ack SHALL still pulse.
REQ-023 adj_req SHALL be held by the requester until adj_ack; adj_field and adj_dir SHALL be stable while adj_req is high.
REQ-024 A tick arriving while busy, or in IDLE while tick_pend is set, SHALL set tick_pend (depth 1).
REQ-025 A tick arriving while tick_pend is already set SHALL be dropped and SHALL set tick_ovf.
REQ-026 tick_pend SHALL clear when T_SEC is entered.
REQ-027 A simultaneous tick and adj_req in IDLE SHALL service the tick first; adj is served on the next IDLE cycle.
REQ-028 Out-of-range field values (e.g. sec=62 forced) SHALL wrap to 0 on the next up-step (the compare is >= limit).

Reset
REQ-029 With rst_n low at a clk edge, the FSM SHALL go to IDLE and sec, min, tick_pend, tick_ovf, adj_ack and busy SHALL become 0.
REQ-030 hour SHALL reset to 0 (12 under TIME_HOUR12_EN).
REQ-031 Reset mid-sequence SHALL abandon the operation; no partial carry survives.

Configuration
REQ-032 Macro TIME_HOUR12_EN defined: hour SHALL range 1..12; up from 12 SHALL give 1; down from 1 SHALL give 12; hour SHALL reset to 12.
REQ-033 Macro TIME_HOUR12_EN undefined: hour SHALL range 0..23 as in REQ-016 and REQ-020.

Structure
REQ-034 A shared package SHALL hold the state enum, field codes, ALU op codes (ADD 2'b00, SUB 2'b01) and limits SEC_LIM=60, MIN_LIM=60, HR_LIM=24/12.
REQ-035 One sub-module, field_wrap, SHALL take alu_data, alu_cout, direction and limit, and output next value and carry-out; it SHALL be instanced once.

Verification
REQ-036 Reset, then a single tick -> sec=1 after 1 cycle, busy high for 1 cycle, alu_s=00, alu_a=0.
REQ-037 Time 23:59:59, then a tick -> 00:00:00 after 3 cycles, with states T_SEC, T_MIN and T_HR in order.
REQ-038 min=0, adj_req with field 01 and dir 1 -> min=59, adj_ack pulses once, hour unchanged.
REQ-039 tick and adj_req(sec, up) in the same cycle with sec=5 -> sec=6 then sec=7, ack on the second operation.
REQ-040 At 00:59:59, tick, then 2 more ticks during the busy window -> one pending tick serviced, tick_ovf=1, final sec=1.
REQ-041 With TIME_HOUR12_EN defined, hour=12 and adj up on hour -> hour=1; after reset, hour=12.

Source files
------------

// File: rtl/time_alu_sequencer_pkg.sv
// Shared definitions for the time-of-day sequencer.
// Holds the FSM state enum, adjust field codes, ALU op codes and field limits.
// Build option: define TIME_HOUR12_EN for a 1..12 hour field that resets to 12.
// Otherwise the hour field runs 0..23 and resets to 0.
package time_alu_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T_SEC,
    T_MIN,
    T_HR,
    ADJ
  } state_t;

  typedef enum logic [1:0] {
    FLD_SEC  = 2'b00,
    FLD_MIN  = 2'b01,
    FLD_HOUR = 2'b10,
    FLD_RSVD = 2'b11
  } field_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  localparam logic [5:0] SEC_LIM = 6'd60;
  localparam logic [5:0] MIN_LIM = 6'd60;

  // HR_BASE is the lowest legal hour; the legal range is HR_BASE..HR_BASE+HR_LIM-1.
`ifdef TIME_HOUR12_EN
  localparam logic [5:0] HR_LIM  = 6'd12;
  localparam logic [5:0] HR_BASE = 6'd1;
  localparam logic [5:0] HR_RST  = 6'd12;
`else
  localparam logic [5:0] HR_LIM  = 6'd24;
  localparam logic [5:0] HR_BASE = 6'd0;
  localparam logic [5:0] HR_RST  = 6'd0;
`endif

endpackage

// File: rtl/time_alu_sequencer_field_wrap.sv
// Applies a field's wrap rule to the shared ALU result.
// Ports: alu_data/alu_cout - ALU result and carry; dir - 0 up, 1 down;
//        limit/base - field spans base..base+limit-1;
//        next_val - value to write back; carry - field wrapped.
module field_wrap (
  input  logic [5:0] alu_data,
  input  logic       alu_cout,
  input  logic       dir,
  input  logic [5:0] limit,
  input  logic [5:0] base,
  output logic [5:0] next_val,
  output logic       carry
);

  logic [5:0] top;
  assign top = limit + base;

  always_comb begin
    next_val = alu_data;
    carry    = 1'b0;
    if (!dir) begin
      // Compare is >= so out-of-range values also return to base; a 6-bit
      // carry-out means the field was 63 and is out of range too.
      if (alu_cout || (alu_data >= top)) begin
        next_val = base;
        carry    = 1'b1;
      end
    end else begin
      // No carry-out from A+~B+1 means a borrow: the field was 0.
      if (!alu_cout || (alu_data < base)) begin
        next_val = top - 6'd1;
        carry    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_alu_sequencer.sv
// Time-of-day sequencer driving a shared external 6-bit ALU.
// Each second tick ripples sec -> min -> hour one ALU op per cycle; user
// adjusts step a single field up or down with no carry.
// Ports: clk, rst_n (sync active-low); tick (1 s pulse);
//        adj_req/adj_field/adj_dir -> adj_ack; alu_a/alu_b/alu_s/alu_cin to ALU,
//        alu_data/alu_cout from ALU; sec/min/hour time fields; busy; tick_ovf.
// Build option: TIME_HOUR12_EN selects a 12-hour hour field.
module time_alu_sequencer
  import time_alu_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       adj_req,
  input  logic [1:0] adj_field,
  input  logic       adj_dir,
  output logic       adj_ack,
  output logic [5:0] alu_a,
  output logic [5:0] alu_b,
  output logic [1:0] alu_s,
  output logic       alu_cin,
  input  logic [5:0] alu_data,
  input  logic       alu_cout,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [5:0] hour,
  output logic       busy,
  output logic       tick_ovf
);

  state_t     state;
  logic       tick_pend;
  field_t     adj_fld;
  logic       adj_dn;

  logic [5:0] adj_cur;
  logic       wrap_dir;
  logic [5:0] wrap_lim;
  logic [5:0] wrap_base;
  logic [5:0] wrap_next;
  logic       wrap_carry;

  always_comb begin
    unique case (adj_fld)
      FLD_SEC:  adj_cur = sec;
      FLD_MIN:  adj_cur = min;
      FLD_HOUR: adj_cur = hour;
      default:  adj_cur = '0;
    endcase
  end

  // ALU drive and wrap rule selection, decoded from the current state.
  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_s     = ALU_ADD;
    alu_cin   = 1'b0;
    wrap_dir  = 1'b0;
    wrap_lim  = SEC_LIM;
    wrap_base = '0;
    unique case (state)
      T_SEC: begin
        alu_a = sec;
        alu_b = 6'd1;
      end
      T_MIN: begin
        alu_a    = min;
        alu_b    = 6'd1;
        wrap_lim = MIN_LIM;
      end
      T_HR: begin
        alu_a     = hour;
        alu_b     = 6'd1;
        wrap_lim  = HR_LIM;
        wrap_base = HR_BASE;
      end
      ADJ: begin
        alu_a = adj_cur;
        alu_b = 6'd1;
        if (adj_dn) begin
          alu_s    = ALU_SUB;
          alu_cin  = 1'b1;
          wrap_dir = 1'b1;
        end
        if (adj_fld == FLD_MIN) begin
          wrap_lim = MIN_LIM;
        end else if (adj_fld == FLD_HOUR) begin
          wrap_lim  = HR_LIM;
          wrap_base = HR_BASE;
        end
      end
      default: ;
    endcase
  end

  field_wrap u_field_wrap (
    .alu_data (alu_data),
    .alu_cout (alu_cout),
    .dir      (wrap_dir),
    .limit    (wrap_lim),
    .base     (wrap_base),
    .next_val (wrap_next),
    .carry    (wrap_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sec       <= '0;
      min       <= '0;
      hour      <= HR_RST;
      tick_pend <= 1'b0;
      tick_ovf  <= 1'b0;
      adj_ack   <= 1'b0;
      busy      <= 1'b0;
      adj_fld   <= FLD_SEC;
      adj_dn    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (tick || tick_pend) begin
            state     <= T_SEC;
            busy      <= 1'b1;
            // The pending slot is consumed; a fresh tick on top of it refills it.
            tick_pend <= tick && tick_pend;
          end else if (adj_req) begin
            state   <= ADJ;
            busy    <= 1'b1;
            adj_ack <= 1'b1;
            adj_fld <= field_t'(adj_field);
            adj_dn  <= adj_dir;
          end
        end
        T_SEC: begin
          sec <= wrap_next;
          if (wrap_carry) begin
            state <= T_MIN;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        T_MIN: begin
          min <= wrap_next;
          if (wrap_carry) begin
            state <= T_HR;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        T_HR: begin
          hour  <= wrap_next;
          state <= IDLE;
          busy  <= 1'b0;
        end
        ADJ: begin
          unique case (adj_fld)
            FLD_SEC:  sec  <= wrap_next;
            FLD_MIN:  min  <= wrap_next;
            FLD_HOUR: hour <= wrap_next;
            default: ;
          endcase
          state   <= IDLE;
          busy    <= 1'b0;
          adj_ack <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if ((state != IDLE) && tick) begin
        if (tick_pend) begin
          tick_ovf <= 1'b1;
        end else begin
          tick_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_time_alu_sequencer.sv
module tb_time_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       adj_req = 1'b0;
  logic [1:0] adj_field = 2'b00;
  logic       adj_dir = 1'b0;
  logic       adj_ack;
  logic [5:0] alu_a, alu_b, alu_data;
  logic [1:0] alu_s;
  logic       alu_cin, alu_cout;
  logic [5:0] sec, min, hour;
  logic       busy, tick_ovf;

`ifdef TIME_HOUR12_EN
  localparam int HR_RST = 12;
`else
  localparam int HR_RST = 0;
`endif

  int checks = 0;
  int errors = 0;
  int m_s, m_m, m_h, m_ovf;

  always #5 clk = ~clk;

  // External ALU: s=01 computes A+~B+Cin, anything else A+B+Cin.
  logic [6:0] alu_sum;
  always_comb begin
    if (alu_s == 2'b01) alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {6'd0, alu_cin};
    else                alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {6'd0, alu_cin};
  end
  assign alu_data = alu_sum[5:0];
  assign alu_cout = alu_sum[6];

  time_alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .adj_req(adj_req), .adj_field(adj_field), .adj_dir(adj_dir), .adj_ack(adj_ack),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
    .alu_data(alu_data), .alu_cout(alu_cout),
    .sec(sec), .min(min), .hour(hour), .busy(busy), .tick_ovf(tick_ovf)
  );

  // ---------------- reference model (clock arithmetic) ----------------
  function automatic int hr_inc(input int h);
`ifdef TIME_HOUR12_EN
    return (h % 12) + 1;
`else
    return (h + 1) % 24;
`endif
  endfunction

  function automatic int hr_dec(input int h);
`ifdef TIME_HOUR12_EN
    return ((h + 10) % 12) + 1;
`else
    return (h + 23) % 24;
`endif
  endfunction

  task automatic m_tick();
    m_s = m_s + 1;
    if (m_s == 60) begin
      m_s = 0;
      m_m = m_m + 1;
      if (m_m == 60) begin
        m_m = 0;
        m_h = hr_inc(m_h);
      end
    end
  endtask

  task automatic m_adj(input int f, input int d);
    case (f)
      0: m_s = d ? (m_s + 59) % 60 : (m_s + 1) % 60;
      1: m_m = d ? (m_m + 59) % 60 : (m_m + 1) % 60;
      2: m_h = d ? hr_dec(m_h) : hr_inc(m_h);
      default: ;
    endcase
  endtask

  function automatic logic [17:0] exp_time();
    return {6'(m_s), 6'(m_m), 6'(m_h)};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick = 1'b0;
    adj_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_s = 0; m_m = 0; m_h = HR_RST; m_ovf = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL wait_idle: busy=%0b after 20 cycles, required 0", busy);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic do_adj(input logic [1:0] f, input logic d, output int acks);
    acks = 0;
    adj_field = f;
    adj_dir = d;
    adj_req = 1'b1;
    for (int i = 0; i < 10 && adj_req; i++) begin
      @(negedge clk);
      if (adj_ack) begin
        acks++;
        adj_req = 1'b0;
      end
    end
    adj_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (adj_ack) acks++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if ({sec, min, hour} !== exp_time()) begin
      errors++;
      $display("FAIL reset_time: got %0d:%0d:%0d, required %0d:%0d:%0d", hour, min, sec, m_h, m_m, m_s);
    end
    checks++;
    if ({busy, adj_ack, tick_ovf} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: busy/ack/ovf got %b, required 000", {busy, adj_ack, tick_ovf});
    end
    checks++;
    if ({alu_s, alu_a, alu_b, alu_cin} !== 15'd0) begin
      errors++;
      $display("FAIL idle_alu: s=%0d a=%0d b=%0d cin=%0b, required all 0", alu_s, alu_a, alu_b, alu_cin);
    end
  endtask

  task automatic test_single_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    checks++;
    if ({busy, sec} !== {1'b1, 6'd0}) begin
      errors++;
      $display("FAIL tick_tsec: busy=%0b sec=%0d, required busy=1 sec=0", busy, sec);
    end
    checks++;
    if ({alu_s, alu_a, alu_b, alu_cin} !== {2'b00, 6'd0, 6'd1, 1'b0}) begin
      errors++;
      $display("FAIL tick_alu: s=%0d a=%0d b=%0d cin=%0b, required s=0 a=0 b=1 cin=0", alu_s, alu_a, alu_b, alu_cin);
    end
    @(negedge clk);
    m_tick();
    checks++;
    if ({busy, sec, min, hour} !== {1'b0, exp_time()}) begin
      errors++;
      $display("FAIL tick_done: busy=%0b time=%0d:%0d:%0d, required busy=0 time=%0d:%0d:%0d", busy, hour, min, sec, m_h, m_m, m_s);
    end
  endtask

  task automatic test_adjust();
    int acks;
    logic [1:0] flds[5] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b11};
    logic       dirs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      do_adj(flds[i], dirs[i], acks);
      m_adj(int'(flds[i]), int'(dirs[i]));
      checks++;
      if (acks !== 1) begin
        errors++;
        $display("FAIL adj_ack[%0d]: ack pulses %0d, required 1", i, acks);
      end
      checks++;
      if ({sec, min, hour} !== exp_time()) begin
        errors++;
        $display("FAIL adj_time[%0d]: got %0d:%0d:%0d, required %0d:%0d:%0d", i, hour, min, sec, m_h, m_m, m_s);
      end
    end
  endtask

  task automatic test_rollover();
    int acks, n, pre_h;
    logic [5:0] trace[4];
    do_reset();
    do_adj(2'b00, 1'b1, acks); m_adj(0, 1);
    do_adj(2'b01, 1'b1, acks); m_adj(1, 1);
`ifndef TIME_HOUR12_EN
    do_adj(2'b10, 1'b1, acks); m_adj(2, 1);
`endif
    checks++;
    if ({sec, min, hour} !== exp_time()) begin
      errors++;
      $display("FAIL roll_setup: got %0d:%0d:%0d, required %0d:%0d:%0d", hour, min, sec, m_h, m_m, m_s);
    end
    pre_h = m_h;
    n = 0;
    tick = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tick = 1'b0;
      if (busy) begin
        if (n < 4) trace[n] = alu_a;
        n++;
      end
    end
    m_tick();
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL roll_cycles: busy cycles %0d, required 3", n);
    end else begin
      checks++;
      if ({trace[0], trace[1], trace[2]} !== {6'd59, 6'd59, 6'(pre_h)}) begin
        errors++;
        $display("FAIL roll_order: alu_a %0d,%0d,%0d, required 59,59,%0d", trace[0], trace[1], trace[2], pre_h);
      end
    end
    checks++;
    if ({sec, min, hour} !== exp_time()) begin
      errors++;
      $display("FAIL roll_time: got %0d:%0d:%0d, required %0d:%0d:%0d", hour, min, sec, m_h, m_m, m_s);
    end
  endtask

  task automatic test_tick_adj_same();
    int acks;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_adj(2'b00, 1'b0, acks);
      m_adj(0, 0);
    end
    tick = 1'b1;
    adj_field = 2'b00;
    adj_dir = 1'b0;
    adj_req = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    checks++;
    if ({sec, busy, adj_ack} !== {6'd5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL same_c1: sec=%0d busy=%0b ack=%0b, required 5 1 0", sec, busy, adj_ack);
    end
    @(negedge clk);
    checks++;
    if ({sec, adj_ack} !== {6'd6, 1'b0}) begin
      errors++;
      $display("FAIL same_c2: sec=%0d ack=%0b, required 6 0", sec, adj_ack);
    end
    @(negedge clk);
    checks++;
    if ({sec, adj_ack} !== {6'd6, 1'b1}) begin
      errors++;
      $display("FAIL same_c3: sec=%0d ack=%0b, required 6 1", sec, adj_ack);
    end
    adj_req = 1'b0;
    @(negedge clk);
    m_tick();
    m_adj(0, 0);
    checks++;
    if ({sec, min, hour, adj_ack, busy} !== {exp_time(), 2'b00}) begin
      errors++;
      $display("FAIL same_c4: time=%0d:%0d:%0d ack=%0b busy=%0b, required %0d:%0d:%0d 0 0", hour, min, sec, adj_ack, busy, m_h, m_m, m_s);
    end
  endtask

  task automatic test_overflow();
    int acks;
    do_reset();
    do_adj(2'b00, 1'b1, acks); m_adj(0, 1);
    do_adj(2'b01, 1'b1, acks); m_adj(1, 1);
    checks++;
    if (tick_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pre: tick_ovf=%0b, required 0", tick_ovf);
    end
    tick = 1'b1;
    repeat (3) @(negedge clk);
    tick = 1'b0;
    checks++;
    if (tick_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: tick_ovf=%0b, required 1", tick_ovf);
    end
    repeat (3) @(negedge clk);
    wait_idle();
    m_tick();
    m_tick();
    m_ovf = 1;
    checks++;
    if ({sec, min, hour, tick_ovf} !== {exp_time(), 1'(m_ovf)}) begin
      errors++;
      $display("FAIL ovf_final: time=%0d:%0d:%0d ovf=%0b, required %0d:%0d:%0d ovf=%0d", hour, min, sec, tick_ovf, m_h, m_m, m_s, m_ovf);
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    do_reset();
    do_adj(2'b00, 1'b1, acks);
    do_adj(2'b01, 1'b1, acks);
    pulse_tick();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_s = 0; m_m = 0; m_h = HR_RST; m_ovf = 0;
    checks++;
    if ({sec, min, hour, busy} !== {exp_time(), 1'b0}) begin
      errors++;
      $display("FAIL rstmid_now: time=%0d:%0d:%0d busy=%0b, required %0d:%0d:%0d 0", hour, min, sec, busy, m_h, m_m, m_s);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({sec, min, hour, busy, tick_ovf} !== {exp_time(), 2'b00}) begin
      errors++;
      $display("FAIL rstmid_after: time=%0d:%0d:%0d busy=%0b, required %0d:%0d:%0d 0", hour, min, sec, busy, m_h, m_m, m_s);
    end
  endtask

  task automatic test_random();
    int acks, f, d;
    do_reset();
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        pulse_tick();
        wait_idle();
        m_tick();
      end else begin
        f = int'($urandom_range(0, 3));
        d = int'($urandom_range(0, 1));
        do_adj(2'(f), 1'(d), acks);
        m_adj(f, d);
        checks++;
        if (acks !== 1) begin
          errors++;
          $display("FAIL rand_ack[%0d]: pulses %0d, required 1", i, acks);
        end
      end
      checks++;
      if ({sec, min, hour} !== exp_time()) begin
        errors++;
        $display("FAIL rand_time[%0d]: got %0d:%0d:%0d, required %0d:%0d:%0d", i, hour, min, sec, m_h, m_m, m_s);
      end
    end
    checks++;
    if (tick_ovf !== 1'b0) begin
      errors++;
      $display("FAIL rand_ovf: tick_ovf=%0b, required 0", tick_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_single_tick();
    test_adjust();
    test_rollover();
    test_tick_adj_same();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
